// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronises the external reset release, holds all domains in reset for a
// fixed time, releases them one by one with a stagger, and runs a per-domain tick divider.
// A rising edge on soft_rst_req while running replays the hold/release sequence.
module rst_seq_gen #(
    parameter int unsigned N_DOM       = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYC    = 16,
    parameter int unsigned STAGGER_CYC = 4,
    parameter int unsigned DIV_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_rst_req,
    input  logic [N_DOM*DIV_W-1:0] div_val,
    output logic [N_DOM-1:0]       dom_rst_n,
    output logic [N_DOM-1:0]       dom_tick,
    output logic                   soft_rst_ack,
    output logic                   seq_busy
);

    // The state register leaving StAssert acts as the final synchroniser stage.
    localparam int unsigned SyncW = SYNC_STAGES - 1;
    localparam int unsigned HoldW = $clog2(HOLD_CYC + 1);
    localparam int unsigned StagW = $clog2(STAGGER_CYC + 1);
    localparam int unsigned IdxW  = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYC - 1);
    localparam logic [StagW-1:0] StagLast = StagW'(STAGGER_CYC - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(N_DOM - 1);

    typedef enum logic [1:0] {
        StAssert,
        StHold,
        StRelease,
        StRun
    } state_t;

    state_t           r_state, w_state_d;
    logic [SyncW-1:0] r_sync;
    logic [HoldW-1:0] r_hold, w_hold_d;
    logic [StagW-1:0] r_stag, w_stag_d;
    logic [IdxW-1:0]  r_idx, w_idx_d;
    logic [N_DOM-1:0] r_rst_n, w_rst_n_d;
    logic             r_soft, w_soft_d;
    logic             r_ack, w_ack_d;
    logic             r_busy, w_busy_d;
    logic             r_soft_prev;
    logic             w_soft_rise;

    assign w_soft_rise = soft_rst_req & ~r_soft_prev;

    // Reset-release synchroniser: assertion is asynchronous, release shifts a 1 through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= 1'b1;
            for (int unsigned k = 1; k < SyncW; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StAssert;
            r_hold      <= '0;
            r_stag      <= '0;
            r_idx       <= '0;
            r_rst_n     <= '0;
            r_soft      <= 1'b0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b1;
            r_soft_prev <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_hold      <= w_hold_d;
            r_stag      <= w_stag_d;
            r_idx       <= w_idx_d;
            r_rst_n     <= w_rst_n_d;
            r_soft      <= w_soft_d;
            r_ack       <= w_ack_d;
            r_busy      <= w_busy_d;
            r_soft_prev <= soft_rst_req;
        end
    end

    // Next-state logic: hold counter, stagger counter and per-domain release vector.
    always_comb begin
        w_state_d = r_state;
        w_hold_d  = r_hold;
        w_stag_d  = r_stag;
        w_idx_d   = r_idx;
        w_rst_n_d = r_rst_n;
        w_soft_d  = r_soft;
        w_ack_d   = 1'b0;
        unique case (r_state)
            StAssert: begin
                w_rst_n_d = '0;
                if (r_sync[SyncW-1]) begin
                    w_state_d = StHold;
                    w_hold_d  = '0;
                end
            end
            StHold: begin
                if (r_hold == HoldLast) begin
                    w_rst_n_d[0] = 1'b1;
                    w_stag_d     = '0;
                    if (N_DOM == 1) begin
                        w_state_d = StRun;
                        w_ack_d   = r_soft;
                        w_soft_d  = 1'b0;
                    end else begin
                        w_state_d = StRelease;
                        w_idx_d   = IdxW'(1);
                    end
                end else begin
                    w_hold_d = r_hold + HoldW'(1);
                end
            end
            StRelease: begin
                if (r_stag == StagLast) begin
                    w_rst_n_d[r_idx] = 1'b1;
                    w_stag_d         = '0;
                    if (r_idx == IdxLast) begin
                        w_state_d = StRun;
                        w_ack_d   = r_soft;
                        w_soft_d  = 1'b0;
                    end else begin
                        w_idx_d = r_idx + IdxW'(1);
                    end
                end else begin
                    w_stag_d = r_stag + StagW'(1);
                end
            end
            StRun: begin
                // Soft reset skips the synchroniser: the request is already in this clock domain.
                if (w_soft_rise) begin
                    w_rst_n_d = '0;
                    w_state_d = StHold;
                    w_hold_d  = '0;
                    w_soft_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = StAssert;
                w_rst_n_d = '0;
            end
        endcase
        w_busy_d = (w_state_d != StRun);
    end

    assign dom_rst_n    = r_rst_n;
    assign soft_rst_ack = r_ack;
    assign seq_busy     = r_busy;

    for (genvar i = 0; i < N_DOM; i++) begin : g_dom
        logic [DIV_W-1:0] r_cnt, r_div, w_cnt_inc, w_div_in;
        logic             r_tick;

        assign w_cnt_inc = r_cnt + DIV_W'(1);
        assign w_div_in  = div_val[i*DIV_W +: DIV_W];

        // Divider: divisor is latched at release and at every wrap, so mid-count changes wait.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt  <= '0;
                r_div  <= '0;
                r_tick <= 1'b0;
            end else if (!w_rst_n_d[i]) begin
                r_cnt  <= '0;
                r_div  <= '0;
                r_tick <= 1'b0;
            end else if (!r_rst_n[i] || (r_cnt == r_div)) begin
                r_cnt  <= '0;
                r_div  <= w_div_in;
                r_tick <= (w_div_in == '0);
            end else begin
                r_cnt  <= w_cnt_inc;
                r_tick <= (w_cnt_inc == r_div);
            end
        end

        assign dom_tick[i] = r_tick;
    end

endmodule

// File: doc/rst_seq_gen.md
RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 SHALL provide parameter N_DOM, default 2: number of reset/tick domains (1..8).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2: reset-deassert synchroniser depth (>=2).
REQ-003 SHALL provide parameter HOLD_CYC, default 16: cycles reset is held after synchronised release (>=1).
REQ-004 SHALL provide parameter STAGGER_CYC, default 4: cycles between consecutive domain releases (>=1).
REQ-005 SHALL provide parameter DIV_W, default 8: tick divider width per domain.
REQ-006 SHALL have port clk, input, 1: single system clock, rising-edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port soft_rst_req, input, 1: soft-reset request, rising-edge detected.
REQ-009 SHALL have port div_val, input, N_DOM*DIV_W: domain i divisor in bits [i*DIV_W +: DIV_W].
REQ-010 SHALL have port dom_rst_n, output, N_DOM: per-domain active-low reset.
REQ-011 SHALL have port dom_tick, output, N_DOM: per-domain clock-enable pulse.
REQ-012 SHALL have port soft_rst_ack, output, 1: one-cycle soft-reset completion pulse.
REQ-013 SHALL have port seq_busy, output, 1: high whenever state is not RUN.

Function
REQ-014 SHALL implement FSM states ASSERT, HOLD, RELEASE, RUN.
REQ-015 ASSERT: all dom_rst_n=0; SHALL move to HOLD on the edge where the synchronised rst first reads high.
REQ-016 HOLD: SHALL count HOLD_CYC edges, then release domain 0 and enter RELEASE (RUN directly if N_DOM=1).
REQ-017 RELEASE: SHALL release domain i exactly STAGGER_CYC edges after domain i-1; the edge releasing domain N_DOM-1 enters RUN.
REQ-018 SHALL make dom_rst_n[0] rise exactly SYNC_STAGES+HOLD_CYC rising edges after rst deassertion (rst meeting setup to the first counted edge).
REQ-019 Once released, dom_rst_n[i] SHALL stay high until rst or an accepted soft reset.
REQ-020 SHALL detect soft_rst_req rising edges (registered previous value); an edge seen in RUN SHALL, on that same edge, drive all dom_rst_n=0 and enter HOLD (no synchroniser delay).
REQ-021 Rising edges of soft_rst_req outside RUN SHALL be ignored; a held-high level SHALL not retrigger.
REQ-022 soft_rst_ack SHALL pulse high for exactly one cycle on the edge entering RUN after a soft reset, never after a rst-initiated sequence.
REQ-023 Per domain, counter SHALL be 0 and dom_tick[i]=0 while dom_rst_n[i]=0.
REQ-024 Released domain: counter SHALL count 0..D, wrapping to 0; dom_tick[i] high while counter==D; D=div_val slice, sampled at release and at each wrap.
REQ-025 div_val=0 SHALL give dom_tick[i] continuously high; div_val=2^DIV_W-1 SHALL give period 2^DIV_W without overflow.
REQ-026 A div_val change mid-count SHALL take effect only after the next wrap.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 rst low SHALL asynchronously force: state ASSERT, dom_rst_n=0, dom_tick=0, soft_rst_ack=0, seq_busy=1, all counters and synchroniser flops 0.
REQ-029 rst low SHALL dominate any simultaneous soft_rst_req or sequence event, including mid-HOLD/RELEASE.
REQ-030 rst deassertion SHALL be synchronised through SYNC_STAGES flops; assertion SHALL not.

Verification (defaults unless stated)
REQ-031 rst low 3 cycles then high -> dom_rst_n[0] rises at edge 18, dom_rst_n[1] at edge 22, seq_busy falls at edge 22, soft_rst_ack stays 0.
REQ-032 RUN, div_val={8'd3,8'd0} -> dom_tick[0] constantly high; dom_tick[1] high 1 cycle in every 4.
REQ-033 RUN, soft_rst_req pulse at edge E -> dom_rst_n=2'b00 at E, dom_rst_n[0] high at E+16, [1] at E+20, soft_rst_ack single pulse at E+20.
REQ-034 soft_rst_req rising during HOLD, then held high into RUN -> ignored, no second sequence, no ack.
REQ-035 rst pulsed low at edge 20 of a power-on sequence -> outputs reset immediately; full sequence restarts, dom_rst_n[0] 18 edges after new deassertion.
REQ-036 N_DOM=4, STAGGER_CYC=1, div_val slice 0 changed 5->2 mid-count -> releases on consecutive edges; period 6 completes, then period 3.
